// File: rtl/wbarbiter_rr2_pkg.sv
// Shared types for the two-master round-robin Wishbone arbiter.
package wbarbiter_rr2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // Round-robin tie break: the master not granted last wins.
    function automatic owner_t tie_winner(input owner_t last);
        return (last == OWN_B) ? OWN_A : OWN_B;
    endfunction

endpackage

// File: rtl/wbarb_timeout.sv
// Stall watchdog: counts enabled, uncleared cycles and flags the cycle whose
// increment would reach TIMEOUT.
module wbarb_timeout #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    assign expire_c = enable && !clear && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/wbarbiter_rr2.sv
// Two-master round-robin arbiter for one pipelined Wishbone slave port, with
// outstanding-request tracking and an optional hung-cycle abort.
module wbarbiter_rr2
    import wbarbiter_rr2_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned LGDEPTH = 4,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_a_cyc,
    input  logic               i_a_stb,
    input  logic               i_a_we,
    input  logic [AW-1:0]      i_a_addr,
    input  logic [DW-1:0]      i_a_data,
    input  logic [DW/8-1:0]    i_a_sel,
    output logic               o_a_ack,
    output logic               o_a_stall,
    output logic               o_a_err,
    input  logic               i_b_cyc,
    input  logic               i_b_stb,
    input  logic               i_b_we,
    input  logic [AW-1:0]      i_b_addr,
    input  logic [DW-1:0]      i_b_data,
    input  logic [DW/8-1:0]    i_b_sel,
    output logic               o_b_ack,
    output logic               o_b_stall,
    output logic               o_b_err,
    output logic [DW-1:0]      o_rdata,
    output logic               o_cyc,
    output logic               o_stb,
    output logic               o_we,
    output logic [AW-1:0]      o_addr,
    output logic [DW-1:0]      o_data,
    output logic [DW/8-1:0]    o_sel,
    input  logic               i_ack,
    input  logic               i_stall,
    input  logic               i_err,
    input  logic [DW-1:0]      i_data,
    output logic [1:0]         o_grant,
    output logic [LGDEPTH-1:0] o_outstanding
);

    localparam int unsigned SW = DW / 8;

    arb_state_t state_q, state_d;
    owner_t     last_q, last_d;
    owner_t     abort_own_q, abort_own_d;
    logic       abort_first_q, abort_first_d;
    logic       expire;

    logic          gnt_a, gnt_b, gnt_any, in_abort;
    logic          own_cyc, own_stb, own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_data;
    logic [SW-1:0] own_sel;
    logic          full, inc, dec, ack_c, err_c, abort_err_c;

    assign gnt_a    = (state_q == ST_GNT_A);
    assign gnt_b    = (state_q == ST_GNT_B);
    assign gnt_any  = gnt_a || gnt_b;
    assign in_abort = (state_q == ST_ABORT);

    // Owner mux; zeroed outside a grant so a non-owner never reaches the slave.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        own_data = '0;
        own_sel  = '0;
        if (gnt_a) begin
            own_cyc  = i_a_cyc;
            own_stb  = i_a_stb;
            own_we   = i_a_we;
            own_addr = i_a_addr;
            own_data = i_a_data;
            own_sel  = i_a_sel;
        end else if (gnt_b) begin
            own_cyc  = i_b_cyc;
            own_stb  = i_b_stb;
            own_we   = i_b_we;
            own_addr = i_b_addr;
            own_data = i_b_data;
            own_sel  = i_b_sel;
        end
    end

    assign full   = (o_outstanding == '1);
    assign o_cyc  = own_cyc;
    assign o_stb  = own_cyc && own_stb && !full;
    assign o_we   = own_we;
    assign o_addr = own_addr;
    assign o_data = own_data;
    assign o_sel  = own_sel;
    assign o_rdata = i_data;

    assign ack_c       = i_ack && o_cyc;
    assign err_c       = i_err && o_cyc;
    assign abort_err_c = in_abort && abort_first_q;

    assign o_a_ack   = gnt_a && ack_c;
    assign o_b_ack   = gnt_b && ack_c;
    assign o_a_err   = (gnt_a && err_c) || (abort_err_c && (abort_own_q == OWN_A));
    assign o_b_err   = (gnt_b && err_c) || (abort_err_c && (abort_own_q == OWN_B));
    assign o_a_stall = !gnt_a || i_stall || full;
    assign o_b_stall = !gnt_b || i_stall || full;

    assign inc = o_stb && !i_stall;
    assign dec = (i_ack || i_err) && o_cyc;

    // Outstanding requests; dropping cyc abandons everything in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset || !o_cyc) begin
            o_outstanding <= '0;
        end else if (inc && !dec) begin
            o_outstanding <= o_outstanding + LGDEPTH'(1);
        end else if (dec && !inc && (o_outstanding != '0)) begin
            o_outstanding <= o_outstanding - LGDEPTH'(1);
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            logic to_clear;
            assign to_clear = !o_cyc || (o_outstanding == '0) || i_ack || i_err;
            wbarb_timeout #(
                .TIMEOUT (TIMEOUT)
            ) u_timeout (
                .i_clk    (i_clk),
                .i_reset  (i_reset),
                .clear    (to_clear),
                .enable   (1'b1),
                .expire_c (expire)
            );
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            last_q        <= OWN_B;
            abort_own_q   <= OWN_A;
            abort_first_q <= 1'b0;
            o_grant       <= 2'b00;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            abort_own_q   <= abort_own_d;
            abort_first_q <= abort_first_d;
            o_grant       <= {state_d == ST_GNT_B, state_d == ST_GNT_A};
        end
    end

    // Arbitration: grants last a whole bus cycle, handoff without an idle gap.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        abort_own_d   = abort_own_q;
        abort_first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_a_cyc && i_b_cyc) begin
                    last_d  = tie_winner(last_q);
                    state_d = (last_d == OWN_A) ? ST_GNT_A : ST_GNT_B;
                end else if (i_a_cyc) begin
                    last_d  = OWN_A;
                    state_d = ST_GNT_A;
                end else if (i_b_cyc) begin
                    last_d  = OWN_B;
                    state_d = ST_GNT_B;
                end
            end
            ST_GNT_A: begin
                if (expire) begin
                    state_d       = ST_ABORT;
                    abort_own_d   = OWN_A;
                    abort_first_d = 1'b1;
                end else if (!i_a_cyc) begin
                    if (i_b_cyc) begin
                        state_d = ST_GNT_B;
                        last_d  = OWN_B;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GNT_B: begin
                if (expire) begin
                    state_d       = ST_ABORT;
                    abort_own_d   = OWN_B;
                    abort_first_d = 1'b1;
                end else if (!i_b_cyc) begin
                    if (i_a_cyc) begin
                        state_d = ST_GNT_A;
                        last_d  = OWN_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ABORT: begin
                if ((abort_own_q == OWN_A) ? !i_a_cyc : !i_b_cyc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wbarbiter_rr2.sv
// Directed bench for wbarbiter_rr2 (LGDEPTH=2, TIMEOUT=8); inputs change at
// posedge+1, outputs are sampled on the falling edge.
module tb_wbarbiter_rr2;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LGDEPTH = 2;
    localparam int unsigned TIMEOUT = 8;

    logic i_clk, i_reset;
    logic i_a_cyc, i_a_stb, i_a_we;
    logic [AW-1:0] i_a_addr;
    logic [DW-1:0] i_a_data;
    logic [DW/8-1:0] i_a_sel;
    logic o_a_ack, o_a_stall, o_a_err;
    logic i_b_cyc, i_b_stb, i_b_we;
    logic [AW-1:0] i_b_addr;
    logic [DW-1:0] i_b_data;
    logic [DW/8-1:0] i_b_sel;
    logic o_b_ack, o_b_stall, o_b_err;
    logic [DW-1:0] o_rdata;
    logic o_cyc, o_stb, o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic [DW/8-1:0] o_sel;
    logic i_ack, i_stall, i_err;
    logic [DW-1:0] i_data;
    logic [1:0] o_grant;
    logic [LGDEPTH-1:0] o_outstanding;

    int checks = 0;
    int errors = 0;

    wbarbiter_rr2 #(.AW(AW), .DW(DW), .LGDEPTH(LGDEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
        .i_a_data(i_a_data), .i_a_sel(i_a_sel),
        .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
        .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
        .i_b_data(i_b_data), .i_b_sel(i_b_sel),
        .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
        .o_rdata(o_rdata), .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr),
        .o_data(o_data), .o_sel(o_sel),
        .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err), .i_data(i_data),
        .o_grant(o_grant), .o_outstanding(o_outstanding)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic to_drive();
        @(posedge i_clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_a_cyc = 1'b0; i_a_stb = 1'b0; i_b_cyc = 1'b0; i_b_stb = 1'b0;
        i_ack = 1'b0; i_err = 1'b0; i_stall = 1'b0;
        to_drive();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) to_drive();
        to_sample();
        if (o_grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", o_grant); end
        checks++;
        if (o_outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", o_outstanding); end
        checks++;
        if ({o_cyc, o_stb} !== 2'b00) begin errors++; $display("FAIL reset_cyc_stb: got %b want 00", {o_cyc, o_stb}); end
        checks++;
        if ({o_a_ack, o_a_err, o_b_ack, o_b_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_ack_err: got %b want 0000", {o_a_ack, o_a_err, o_b_ack, o_b_err});
        end
        checks++;
        if ({o_a_stall, o_b_stall} !== 2'b11) begin errors++; $display("FAIL reset_stalls: got %b want 11", {o_a_stall, o_b_stall}); end
        checks++;
        to_drive();
        i_reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_we = 1'b0; i_a_addr = 32'h100; i_a_data = 32'h11; i_a_sel = 4'hF;
        i_b_addr = 32'hDEAD; i_b_we = 1'b1; i_b_data = 32'h22; i_b_sel = 4'h3;
        to_sample();
        if (o_grant !== 2'b00 || o_cyc !== 1'b0 || o_a_stall !== 1'b1) begin
            errors++; $display("FAIL basic_idle: grant=%b cyc=%b a_stall=%b want 00 0 1", o_grant, o_cyc, o_a_stall);
        end
        checks++;
        to_drive();
        to_sample();
        if (o_grant !== 2'b01) begin errors++; $display("FAIL basic_grant: got %b want 01", o_grant); end
        checks++;
        if (o_stb !== 1'b1 || o_addr !== 32'h100) begin
            errors++; $display("FAIL basic_stb_addr: stb=%b addr=%h want 1 00000100", o_stb, o_addr);
        end
        checks++;
        if (o_we !== 1'b0 || o_data !== 32'h11 || o_sel !== 4'hF) begin
            errors++; $display("FAIL basic_route: we=%b data=%h sel=%h want 0 00000011 f", o_we, o_data, o_sel);
        end
        checks++;
        if (o_a_stall !== 1'b0 || o_b_stall !== 1'b1) begin
            errors++; $display("FAIL basic_stalls: a=%b b=%b want 0 1", o_a_stall, o_b_stall);
        end
        checks++;
        to_drive();
        i_a_stb = 1'b0; i_ack = 1'b1; i_data = 32'hCAFE;
        to_sample();
        if (o_outstanding !== 2'd1) begin errors++; $display("FAIL basic_out1: got %0d want 1", o_outstanding); end
        checks++;
        if (o_a_ack !== 1'b1 || o_b_ack !== 1'b0 || o_rdata !== 32'hCAFE || o_b_stall !== 1'b1) begin
            errors++; $display("FAIL basic_ack: a_ack=%b b_ack=%b rdata=%h b_stall=%b want 1 0 0000cafe 1", o_a_ack, o_b_ack, o_rdata, o_b_stall);
        end
        checks++;
        to_drive();
        to_sample();
        if (o_outstanding !== 2'd0) begin errors++; $display("FAIL basic_out0: got %0d want 0", o_outstanding); end
        checks++;
        to_drive();
        i_ack = 1'b0; i_a_cyc = 1'b0;
        to_sample();
        if (o_outstanding !== 2'd0 || o_cyc !== 1'b0) begin
            errors++; $display("FAIL basic_saturate: out=%0d cyc=%b want 0 0", o_outstanding, o_cyc);
        end
        checks++;
        to_drive();
        to_sample();
        if (o_grant !== 2'b00) begin errors++; $display("FAIL basic_release: got %b want 00", o_grant); end
        checks++;
    endtask

    task automatic test_tie();
        do_reset();
        i_a_cyc = 1'b1; i_b_cyc = 1'b1;
        to_sample();
        if (o_grant !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", o_grant); end
        checks++;
        to_drive();
        to_sample();
        if (o_grant !== 2'b01 || o_b_stall !== 1'b1 || o_a_stall !== 1'b0) begin
            errors++; $display("FAIL tie_first_a: grant=%b a_stall=%b b_stall=%b want 01 0 1", o_grant, o_a_stall, o_b_stall);
        end
        checks++;
        to_drive();
        i_a_cyc = 1'b0;
        to_sample();
        if (o_cyc !== 1'b0 || o_grant !== 2'b01) begin
            errors++; $display("FAIL tie_drop: cyc=%b grant=%b want 0 01", o_cyc, o_grant);
        end
        checks++;
        to_drive();
        to_sample();
        if (o_grant !== 2'b10 || o_b_stall !== 1'b0 || o_a_stall !== 1'b1 || o_cyc !== 1'b1) begin
            errors++; $display("FAIL tie_handoff_b: grant=%b a_stall=%b b_stall=%b cyc=%b want 10 1 0 1", o_grant, o_a_stall, o_b_stall, o_cyc);
        end
        checks++;
        to_drive();
        i_b_cyc = 1'b0;
        to_drive();
        to_sample();
        if (o_grant !== 2'b00) begin errors++; $display("FAIL tie_idle2: got %b want 00", o_grant); end
        checks++;
        to_drive();
        i_a_cyc = 1'b1; i_b_cyc = 1'b1;
        to_drive();
        to_sample();
        if (o_grant !== 2'b01) begin errors++; $display("FAIL tie_second_a: got %b want 01", o_grant); end
        checks++;
        to_drive();
        i_a_cyc = 1'b0; i_b_cyc = 1'b0;
        to_drive();
        i_a_cyc = 1'b1; i_b_cyc = 1'b1;
        to_drive();
        to_sample();
        if (o_grant !== 2'b10) begin errors++; $display("FAIL tie_third_b: got %b want 10", o_grant); end
        checks++;
        to_drive();
        i_a_cyc = 1'b0; i_b_cyc = 1'b0;
        to_drive();
    endtask

    task automatic test_full();
        do_reset();
        i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 32'h200;
        repeat (4) to_drive();
        i_ack = 1'b1;
        to_sample();
        if (o_outstanding !== 2'd3) begin errors++; $display("FAIL full_count: got %0d want 3", o_outstanding); end
        checks++;
        if (o_stb !== 1'b0 || o_a_stall !== 1'b1 || o_cyc !== 1'b1 || o_a_ack !== 1'b1) begin
            errors++; $display("FAIL full_gate: stb=%b a_stall=%b cyc=%b ack=%b want 0 1 1 1", o_stb, o_a_stall, o_cyc, o_a_ack);
        end
        checks++;
        to_drive();
        to_sample();
        if (o_outstanding !== 2'd2 || o_stb !== 1'b1 || o_a_stall !== 1'b0) begin
            errors++; $display("FAIL full_resume: out=%0d stb=%b a_stall=%b want 2 1 0", o_outstanding, o_stb, o_a_stall);
        end
        checks++;
        to_drive();
        i_ack = 1'b0; i_a_stb = 1'b0; i_a_cyc = 1'b0;
        to_sample();
        if (o_outstanding !== 2'd2 || o_cyc !== 1'b0) begin
            errors++; $display("FAIL full_simul: out=%0d cyc=%b want 2 0", o_outstanding, o_cyc);
        end
        checks++;
        to_drive();
        to_sample();
        if (o_outstanding !== 2'd0 || o_grant !== 2'b00) begin
            errors++; $display("FAIL full_drop_clear: out=%0d grant=%b want 0 00", o_outstanding, o_grant);
        end
        checks++;
    endtask

    task automatic test_timeout();
        do_reset();
        i_a_cyc = 1'b1; i_a_stb = 1'b1;
        to_drive();
        to_drive();
        i_a_stb = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            to_sample();
            if (o_a_err !== 1'b0 || o_cyc !== 1'b1) begin
                errors++; $display("FAIL timeout_wait%0d: err=%b cyc=%b want 0 1", k, o_a_err, o_cyc);
            end
            checks++;
            to_drive();
        end
        to_sample();
        if (o_a_err !== 1'b1 || o_b_err !== 1'b0 || o_cyc !== 1'b0 || o_grant !== 2'b00 || o_a_stall !== 1'b1) begin
            errors++; $display("FAIL timeout_abort: a_err=%b b_err=%b cyc=%b grant=%b a_stall=%b want 1 0 0 00 1", o_a_err, o_b_err, o_cyc, o_grant, o_a_stall);
        end
        checks++;
        to_drive();
        i_b_cyc = 1'b1;
        to_sample();
        if (o_a_err !== 1'b0 || o_a_stall !== 1'b1 || o_outstanding !== 2'd0 || o_grant !== 2'b00) begin
            errors++; $display("FAIL timeout_hold: err=%b stall=%b out=%0d grant=%b want 0 1 0 00", o_a_err, o_a_stall, o_outstanding, o_grant);
        end
        checks++;
        to_drive();
        i_a_cyc = 1'b0;
        to_sample();
        if (o_grant !== 2'b00 || o_b_stall !== 1'b1) begin
            errors++; $display("FAIL timeout_no_steal: grant=%b b_stall=%b want 00 1", o_grant, o_b_stall);
        end
        checks++;
        to_drive();
        to_sample();
        if (o_grant !== 2'b00) begin errors++; $display("FAIL timeout_idle: got %b want 00", o_grant); end
        checks++;
        to_drive();
        to_sample();
        if (o_grant !== 2'b10) begin errors++; $display("FAIL timeout_regrant: got %b want 10", o_grant); end
        checks++;
        to_drive();
        i_b_cyc = 1'b0;
        to_drive();
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_a_cyc = 1'b1; i_a_stb = 1'b1;
        repeat (3) to_drive();
        i_a_stb = 1'b0; i_reset = 1'b1;
        to_sample();
        if (o_outstanding !== 2'd2) begin errors++; $display("FAIL midrst_pre: got %0d want 2", o_outstanding); end
        checks++;
        to_drive();
        i_reset = 1'b0; i_ack = 1'b1;
        to_sample();
        if (o_grant !== 2'b00 || o_outstanding !== 2'd0 || o_cyc !== 1'b0) begin
            errors++; $display("FAIL midrst_state: grant=%b out=%0d cyc=%b want 00 0 0", o_grant, o_outstanding, o_cyc);
        end
        checks++;
        if ({o_a_stall, o_b_stall} !== 2'b11 || o_a_ack !== 1'b0) begin
            errors++; $display("FAIL midrst_resp: stalls=%b ack=%b want 11 0", {o_a_stall, o_b_stall}, o_a_ack);
        end
        checks++;
        to_drive();
        i_ack = 1'b0; i_a_cyc = 1'b0;
        repeat (2) to_drive();
    endtask

    initial begin
        i_reset = 1'b1;
        i_a_cyc = 1'b0; i_a_stb = 1'b0; i_a_we = 1'b0; i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
        i_b_cyc = 1'b0; i_b_stb = 1'b0; i_b_we = 1'b0; i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
        i_ack = 1'b0; i_stall = 1'b0; i_err = 1'b0; i_data = '0;
        test_reset();
        test_basic();
        test_tie();
        test_full();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
